// File: rtl/vga_pkg.sv
// Shared VGA geometry, pixel colour type and colour-zone helper for the spectrum display.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t COL_BLACK  = '{r: 8'h00, g: 8'h00, b: 8'h00};
    localparam rgb_t COL_GREEN  = '{r: 8'h00, g: 8'hff, b: 8'h00};
    localparam rgb_t COL_YELLOW = '{r: 8'hff, g: 8'hff, b: 8'h00};
    localparam rgb_t COL_RED    = '{r: 8'hff, g: 8'h00, b: 8'h00};

    // Heights are measured upward from the bottom row of the active area.
    localparam int ZONE_GREEN_H  = 160;
    localparam int ZONE_YELLOW_H = 320;

    function automatic rgb_t zone_colour(input logic [9:0] h);
        if (h < 10'(ZONE_GREEN_H)) begin
            return COL_GREEN;
        end else if (h < 10'(ZONE_YELLOW_H)) begin
            return COL_YELLOW;
        end else begin
            return COL_RED;
        end
    endfunction

endpackage

// File: rtl/spectrum_bin_store.sv
// Double-buffered magnitude store: FFT writes the shadow buffer, which is copied
// into the display buffer on the first vsync falling edge after a completed set.
module spectrum_bin_store #(
    parameter int NUM_BINS = 16,
    parameter int MAG_W    = 8,
    parameter int IDX_W    = $clog2(NUM_BINS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [MAG_W-1:0] wr_mag,
    input  logic             wr_last,
    input  logic             vsync_in,
    output logic             frame_swapped,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [MAG_W-1:0] rd_mag
);

    logic [MAG_W-1:0] shadow_q  [NUM_BINS];
    logic [MAG_W-1:0] shadow_d  [NUM_BINS];
    logic [MAG_W-1:0] display_q [NUM_BINS];
    logic [MAG_W-1:0] display_d [NUM_BINS];
    logic             pending_q, pending_d;
    logic             vs_prev_q, vs_prev_d;
    logic             swapped_q, swapped_d;
    logic             accept;
    logic             vs_fall;

    always_comb begin
        shadow_d  = shadow_q;
        display_d = display_q;
        pending_d = pending_q;
        swapped_d = 1'b0;
        vs_prev_d = vsync_in;

        accept  = wr_valid & ~pending_q;
        vs_fall = vs_prev_q & ~vsync_in;

        // The edge sees the pending flag from before this cycle's handshake,
        // so a set completed on the edge itself waits for the next frame.
        if (vs_fall && pending_q) begin
            display_d = shadow_q;
            pending_d = 1'b0;
            swapped_d = 1'b1;
        end

        if (accept) begin
            shadow_d[wr_idx] = wr_mag;
            if (wr_last) begin
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '{default: '0};
            display_q <= '{default: '0};
            pending_q <= 1'b0;
            vs_prev_q <= 1'b1;
            swapped_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            display_q <= display_d;
            pending_q <= pending_d;
            vs_prev_q <= vs_prev_d;
            swapped_q <= swapped_d;
        end
    end

    assign wr_ready      = ~pending_q;
    assign frame_swapped = swapped_q;
    assign rd_mag        = display_q[rd_idx];

endmodule

// File: rtl/spectrum_bar_gen.sv
// Two-stage pixel pipeline that draws NUM_BINS vertical magnitude bars, with
// hsync/vsync delayed alongside so they stay aligned with r/g/b.
module spectrum_bar_gen
    import vga_pkg::*;
#(
    parameter int NUM_BINS = 16,
    parameter int MAG_W    = 8,
    parameter int BAR_W    = 40,
    parameter int GAP_W    = 4
) (
    input  logic                        vgaclk,
    input  logic                        resetn,
    input  logic [9:0]                  x,
    input  logic [9:0]                  y,
    input  logic                        hsync_in,
    input  logic                        vsync_in,
    input  logic                        bin_valid,
    output logic                        bin_ready,
    input  logic [$clog2(NUM_BINS)-1:0] bin_idx,
    input  logic [MAG_W-1:0]            bin_mag,
    input  logic                        bin_last,
    output logic                        hsync,
    output logic                        vsync,
    output logic [7:0]                  r,
    output logic [7:0]                  g,
    output logic [7:0]                  b,
    output logic                        frame_swapped
);

    localparam int IDX_W = $clog2(NUM_BINS);
    localparam int COL_W = $clog2(BAR_W);

    logic [IDX_W-1:0] bin_p1_q, bin_p1_d;
    logic [COL_W-1:0] col_p1_q, col_p1_d;
    logic [9:0]       y_p1_q, y_p1_d;
    logic             active_p1_q, active_p1_d;
    logic             hs_p1_q, vs_p1_q;
    logic             hs_p2_q, vs_p2_q;
    rgb_t             rgb_p2_q, rgb_p2_d;

    logic [4:0]       bin_full;
    logic [MAG_W-1:0] mag;
    logic [9:0]       h;
    logic [MAG_W:0]   bar_top;
    logic             lit;

    spectrum_bin_store #(
        .NUM_BINS (NUM_BINS),
        .MAG_W    (MAG_W),
        .IDX_W    (IDX_W)
    ) u_store (
        .clk           (vgaclk),
        .rst_n         (resetn),
        .wr_valid      (bin_valid),
        .wr_ready      (bin_ready),
        .wr_idx        (bin_idx),
        .wr_mag        (bin_mag),
        .wr_last       (bin_last),
        .vsync_in      (vsync_in),
        .frame_swapped (frame_swapped),
        .rd_idx        (bin_p1_q),
        .rd_mag        (mag)
    );

    // S1: bin index via reciprocal multiply (x*205 >> 13 == x/40 for x < 640).
    always_comb begin
        bin_full    = 5'(({8'd0, x} * 18'd205) >> 13);
        bin_p1_d    = IDX_W'(bin_full);
        col_p1_d    = COL_W'(x - 10'(bin_full) * 10'(BAR_W));
        y_p1_d      = y;
        active_p1_d = (x < 10'(H_ACTIVE)) && (y < 10'(V_ACTIVE));
    end

    // S2: bar height test and colour zone.
    always_comb begin
        h        = 10'(V_ACTIVE - 1) - y_p1_q;
        bar_top  = {mag, 1'b0};
        lit      = active_p1_q
                   && (col_p1_q < COL_W'(BAR_W - GAP_W))
                   && (32'(h) < 32'(bar_top));
        rgb_p2_d = lit ? zone_colour(h) : COL_BLACK;
    end

    always_ff @(posedge vgaclk or negedge resetn) begin
        if (!resetn) begin
            bin_p1_q    <= '0;
            col_p1_q    <= '0;
            y_p1_q      <= '0;
            active_p1_q <= 1'b0;
            hs_p1_q     <= 1'b1;
            vs_p1_q     <= 1'b1;
            hs_p2_q     <= 1'b1;
            vs_p2_q     <= 1'b1;
            rgb_p2_q    <= COL_BLACK;
        end else begin
            bin_p1_q    <= bin_p1_d;
            col_p1_q    <= col_p1_d;
            y_p1_q      <= y_p1_d;
            active_p1_q <= active_p1_d;
            hs_p1_q     <= hsync_in;
            vs_p1_q     <= vsync_in;
            hs_p2_q     <= hs_p1_q;
            vs_p2_q     <= vs_p1_q;
            rgb_p2_q    <= rgb_p2_d;
        end
    end

    assign hsync = hs_p2_q;
    assign vsync = vs_p2_q;
    assign r     = rgb_p2_q.r;
    assign g     = rgb_p2_q.g;
    assign b     = rgb_p2_q.b;

endmodule

// File: tb/tb_spectrum_bar_gen.sv
// Directed bench for spectrum_bar_gen: load/swap handshake, bar rendering, latency and reset.
module tb_spectrum_bar_gen;

    logic       vgaclk = 1'b0;
    logic       resetn = 1'b0;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic       bin_valid = 1'b0;
    logic       bin_ready;
    logic [3:0] bin_idx = '0;
    logic [7:0] bin_mag = '0;
    logic       bin_last = 1'b0;
    logic       hsync, vsync;
    logic [7:0] r, g, b;
    logic       frame_swapped;

    int total  = 0;
    int passed = 0;

    localparam logic [23:0] BLACK  = 24'h000000;
    localparam logic [23:0] GREEN  = 24'h00ff00;
    localparam logic [23:0] YELLOW = 24'hffff00;
    localparam logic [23:0] RED    = 24'hff0000;

    always #20 vgaclk = ~vgaclk;

    spectrum_bar_gen dut (
        .vgaclk        (vgaclk),
        .resetn        (resetn),
        .x             (x),
        .y             (y),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .bin_valid     (bin_valid),
        .bin_ready     (bin_ready),
        .bin_idx       (bin_idx),
        .bin_mag       (bin_mag),
        .bin_last      (bin_last),
        .hsync         (hsync),
        .vsync         (vsync),
        .r             (r),
        .g             (g),
        .b             (b),
        .frame_swapped (frame_swapped)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic write_bin(input int idx, input int mag, input logic last);
        @(negedge vgaclk);
        bin_valid = 1'b1;
        bin_idx   = 4'(idx);
        bin_mag   = 8'(mag);
        bin_last  = last;
        @(negedge vgaclk);
        bin_valid = 1'b0;
        bin_last  = 1'b0;
    endtask

    task automatic vsync_edge(output int pulses);
        pulses = 0;
        @(negedge vgaclk);
        vsync_in = 1'b0;
        repeat (4) begin
            @(negedge vgaclk);
            if (frame_swapped) pulses++;
        end
        vsync_in = 1'b1;
        repeat (3) begin
            @(negedge vgaclk);
            if (frame_swapped) pulses++;
        end
    endtask

    task automatic pixel(input int px, input int py, output logic [23:0] c);
        @(negedge vgaclk);
        x = 10'(px);
        y = 10'(py);
        @(negedge vgaclk);
        @(negedge vgaclk);
        c = {r, g, b};
    endtask

    task automatic scan_frame(output int lit);
        int n;
        n   = 0;
        lit = 0;
        for (int yy = 0; yy < 480; yy += 32) begin
            for (int xx = 0; xx < 640; xx += 3) begin
                @(negedge vgaclk);
                if (n >= 2 && {r, g, b} != 24'h0) lit++;
                x = 10'(xx);
                y = 10'(yy);
                n++;
            end
        end
        repeat (2) begin
            @(negedge vgaclk);
            if ({r, g, b} != 24'h0) lit++;
        end
    endtask

    initial begin
        logic [23:0] c;
        int          pulses;
        int          lit;

        // Reset state
        repeat (3) @(negedge vgaclk);
        check_eq("reset_rgb", {8'h0, r, g, b}, 32'h0);
        check_eq("reset_hsync", 32'(hsync), 32'd1);
        check_eq("reset_vsync", 32'(vsync), 32'd1);
        check_eq("reset_ready", 32'(bin_ready), 32'd1);
        check_eq("reset_swapped", 32'(frame_swapped), 32'd0);
        resetn = 1'b1;

        // Writes without bin_last never swap
        write_bin(0, 255, 1'b0);
        check_eq("nolast_ready", 32'(bin_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            vsync_edge(pulses);
            check_eq("nolast_pulses", 32'(pulses), 32'd0);
        end
        pixel(10, 0, c);
        check_eq("nolast_px_10_0", 32'(c), 32'(BLACK));

        // Load bins 3 and 15 with bin_last, then swap
        write_bin(3, 100, 1'b0);
        check_eq("load_ready_mid", 32'(bin_ready), 32'd1);
        write_bin(15, 255, 1'b1);
        check_eq("load_ready_pending", 32'(bin_ready), 32'd0);
        vsync_edge(pulses);
        check_eq("load_pulses", 32'(pulses), 32'd1);
        check_eq("load_ready_after", 32'(bin_ready), 32'd1);
        pixel(130, 479, c);
        check_eq("px_130_479", 32'(c), 32'(GREEN));
        pixel(130, 279, c);
        check_eq("px_130_279", 32'(c), 32'(BLACK));
        pixel(130, 280, c);
        check_eq("px_130_280", 32'(c), 32'(YELLOW));
        pixel(620, 0, c);
        check_eq("px_620_0", 32'(c), 32'(RED));
        pixel(639, 0, c);
        check_eq("px_639_0_gap", 32'(c), 32'(BLACK));
        pixel(155, 479, c);
        check_eq("px_155_479_lastcol", 32'(c), 32'(GREEN));
        pixel(156, 479, c);
        check_eq("px_156_479_gap", 32'(c), 32'(BLACK));
        pixel(10, 0, c);
        check_eq("px_10_0_bin0", 32'(c), 32'(RED));
        pixel(50, 479, c);
        check_eq("px_50_479_zero", 32'(c), 32'(BLACK));
        pixel(130, 480, c);
        check_eq("px_130_480_blank", 32'(c), 32'(BLACK));

        // Latency: colour and sync change two cycles after the input change
        pixel(130, 279, c);
        @(negedge vgaclk);
        y        = 10'd400;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        @(negedge vgaclk);
        check_eq("lat1_rgb", {8'h0, r, g, b}, 32'(BLACK));
        check_eq("lat1_hsync", 32'(hsync), 32'd1);
        check_eq("lat1_vsync", 32'(vsync), 32'd1);
        @(negedge vgaclk);
        check_eq("lat2_rgb", {8'h0, r, g, b}, 32'(GREEN));
        check_eq("lat2_hsync", 32'(hsync), 32'd0);
        check_eq("lat2_vsync", 32'(vsync), 32'd0);
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        repeat (3) @(negedge vgaclk);

        // Double write of bin 5, bin_last coincident with vsync edge
        write_bin(5, 50, 1'b0);
        write_bin(5, 200, 1'b0);
        @(negedge vgaclk);
        vsync_in  = 1'b0;
        bin_valid = 1'b1;
        bin_idx   = 4'd7;
        bin_mag   = 8'd0;
        bin_last  = 1'b1;
        @(negedge vgaclk);
        bin_valid = 1'b0;
        bin_last  = 1'b0;
        pulses    = 0;
        repeat (4) begin
            @(negedge vgaclk);
            if (frame_swapped) pulses++;
        end
        vsync_in = 1'b1;
        check_eq("coinc_pulses", 32'(pulses), 32'd0);
        check_eq("coinc_ready", 32'(bin_ready), 32'd0);
        pixel(200, 80, c);
        check_eq("coinc_px_200_80_old", 32'(c), 32'(BLACK));
        vsync_edge(pulses);
        check_eq("coinc_next_pulses", 32'(pulses), 32'd1);
        pixel(200, 80, c);
        check_eq("px_200_80", 32'(c), 32'(RED));
        pixel(200, 79, c);
        check_eq("px_200_79", 32'(c), 32'(BLACK));

        // Asynchronous reset mid-frame with a pending set
        write_bin(2, 10, 1'b1);
        @(negedge vgaclk);
        x        = 10'd130;
        y        = 10'd479;
        hsync_in = 1'b0;
        repeat (3) @(negedge vgaclk);
        check_eq("pre_rst_rgb", {8'h0, r, g, b}, 32'(GREEN));
        check_eq("pre_rst_hsync", 32'(hsync), 32'd0);
        check_eq("pre_rst_ready", 32'(bin_ready), 32'd0);
        #7;
        resetn = 1'b0;
        #1;
        check_eq("async_rst_rgb", {8'h0, r, g, b}, 32'h0);
        check_eq("async_rst_hsync", 32'(hsync), 32'd1);
        check_eq("async_rst_vsync", 32'(vsync), 32'd1);
        check_eq("async_rst_ready", 32'(bin_ready), 32'd1);
        @(negedge vgaclk);
        resetn   = 1'b1;
        hsync_in = 1'b1;
        scan_frame(lit);
        check_eq("post_rst_lit", 32'(lit), 32'd0);
        vsync_edge(pulses);
        check_eq("post_rst_pulses", 32'(pulses), 32'd0);
        pixel(130, 479, c);
        check_eq("post_rst_px", 32'(c), 32'(BLACK));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
